pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, successor to the fixed ID/EX latch.
- Carries a DATA_W payload and a CTRL_W control bundle between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, synchronous flush that inserts a bubble, an optional 2-entry skid buffer that registers backpressure, and a saturating stall counter.

Parameters:
DATA_W, 32, payload width (pc, operands, immediate, instruction)
CTRL_W, 16, control bundle width (RegWrite, MemRead, ALUOp, ...); forced to zero in bubbles
SKID, 1, 1 = two-entry skid buffer with registered ready_o; 0 = single register with combinational ready_o
PERF_W, 16, stall counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
flush_i  in  1  synchronous kill of all held entries
valid_i  in  1  upstream beat valid
ready_o  out  1  stage can accept a beat
data_i  in  DATA_W  upstream payload
ctrl_i  in  CTRL_W  upstream control bundle
valid_o  out  1  downstream beat valid
ready_i  in  1  downstream accepts
data_o  out  DATA_W  payload of head entry
ctrl_o  out  CTRL_W  control of head entry; all-zero when valid_o=0
count_o  out  2  occupancy, 0..2 (0..1 when SKID=0)
stall_cnt_o  out  PERF_W  cycles with valid_o=1 and ready_i=0, saturating

Behaviour:
- Reset (rst_i=1, asynchronous): all storage cleared.
  - valid_o=0, data_o=0, ctrl_o=0, count_o=0, stall_cnt_o=0, ready_o=1.
- Handshake definitions:
  - in_xfer = valid_i & ready_o.
  - out_xfer = valid_o & ready_i.
  - Latency is 1 cycle from in_xfer to valid_o when the stage is empty.
- SKID=0:
  - ready_o = ~valid_o | ready_i (combinational).
  - On in_xfer, the head loads data_i/ctrl_i.
  - On out_xfer without in_xfer, the head empties.
- SKID=1, states EMPTY/ONE/TWO:
  - ready_o = (state != TWO), decoded from a register only.
  - EMPTY: in_xfer -> ONE, head <= input.
  - ONE:
    - in_xfer & ~out_xfer -> TWO, skid <= input.
    - in_xfer & out_xfer -> ONE, head <= input.
    - ~in_xfer & out_xfer -> EMPTY.
    - otherwise hold.
  - TWO: out_xfer -> ONE, head <= skid; otherwise hold. in_xfer is impossible because ready_o=0.
  - Ordering is strictly FIFO. No beat is duplicated or lost without a flush.
- count_o = 0/1/2 for EMPTY/ONE/TWO.
- Flush:
  - flush_i has the highest priority over all transfers. The next state is EMPTY and valid_o=0 on the next cycle.
  - A beat presented with valid_i in the flush cycle is discarded, even if ready_o=1.
  - An out_xfer in the flush cycle still counts as delivered, since downstream sampled it.
  - data_o is undefined after a flush; ctrl_o is guaranteed zero.
- Bubble rule: ctrl_o = valid_o ? head_ctrl : 0, so downstream stages never see stale write/memory enables.
- stall_cnt_o:
  - Increments each cycle where valid_o & ~ready_i.
  - Saturates at 2^PERF_W-1.
  - Unaffected by flush; cleared only by rst_i.
- Reset asserted mid-operation clears everything immediately, including in-flight beats and the counter.
- data_o and ctrl_o must be stable while valid_o=1 and ready_i=0.

Test Plan:
- Streaming, SKID=1, ready_i=1: beats A=0x11, B=0x22, C=0x33 on consecutive cycles -> data_o shows A, B, C one cycle later each; count_o stays 1; ready_o stays 1; stall_cnt_o=0.
- Backpressure: send A, B with ready_i=0 -> count_o=2, ready_o=0 in cycle 3, C held upstream; data_o=A stable; stall_cnt_o increments each cycle. Raise ready_i -> A, B, C delivered in order with no loss.
- Flush with TWO entries plus valid_i=1 (ctrl_i=0xFFFF) -> next cycle valid_o=0, ctrl_o=0, count_o=0, ready_o=1; the incoming beat never appears.
- Async reset asserted between clock edges while count_o=2 -> outputs zero immediately, before the next edge; first beat after deassertion passes with 1-cycle latency.
- SKID=0 build: ready_i toggling 1,0,1 -> ready_o follows ~valid_o|ready_i in the same cycle; occupancy never exceeds 1.
- Counter saturation, PERF_W=4: hold valid_o=1 and ready_i=0 for 20 cycles -> stall_cnt_o=15 and does not wrap.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, synchronous flush,
// optional two-entry skid buffer and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned SKID   = 1,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [1:0]        count_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StTwo = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              in_xfer, out_xfer;

  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload, skid and stall counter storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
    end else begin
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_q     <= stall_d;
    end
  end

  // Next state and datapath loads; flush overrides every transfer
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            state_d     = StOne;
            head_data_d = data_i;
            head_ctrl_d = ctrl_i;
          end
        end
        StOne: begin
          if (in_xfer && out_xfer) begin
            head_data_d = data_i;
            head_ctrl_d = ctrl_i;
          end else if (in_xfer) begin
            // Only reachable with the skid buffer; without it ready_o implies ready_i here
            state_d     = StTwo;
            skid_data_d = data_i;
            skid_ctrl_d = ctrl_i;
          end else if (out_xfer) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_xfer) begin
            state_d     = StOne;
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end

    // Stall counter ignores flush and sticks at all-ones
    stall_d = stall_q;
    if (valid_o && !ready_i && (stall_q != '1)) begin
      stall_d = stall_q + PERF_W'(1);
    end
  end

  // Outputs decoded from registered state; ctrl is zeroed in bubbles
  always_comb begin
    valid_o = (state_q != StEmpty);
    if (SKID != 0) begin
      ready_o = (state_q != StTwo);
    end else begin
      ready_o = ~valid_o | ready_i;
    end
    data_o = head_data_q;
    ctrl_o = valid_o ? head_ctrl_q : '0;
    unique case (state_q)
      StEmpty: count_o = 2'd0;
      StOne:   count_o = 2'd1;
      StTwo:   count_o = 2'd2;
      default: count_o = 2'd0;
    endcase
    stall_cnt_o = stall_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a skid build with a 4-bit stall counter and a
// single-register build, checked by a forked monitor plus directed status checks.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;

  // Skid build (SKID=1, PERF_W=4)
  logic        v1_in, r1_out, v1_out, r1_in;
  logic [31:0] d1_in, d1_out;
  logic [15:0] c1_in, c1_out;
  logic [1:0]  cnt1;
  logic [3:0]  stall1;

  // Single-register build (SKID=0)
  logic        v0_in, r0_out, v0_out, r0_in;
  logic [31:0] d0_in, d0_out;
  logic [15:0] c0_in, c0_out;
  logic [1:0]  cnt0;
  logic [15:0] stall0;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .PERF_W(4)) u_skid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .valid_i(v1_in), .ready_o(r1_out), .data_i(d1_in), .ctrl_i(c1_in),
    .valid_o(v1_out), .ready_i(r1_in), .data_o(d1_out), .ctrl_o(c1_out),
    .count_o(cnt1), .stall_cnt_o(stall1)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0), .PERF_W(16)) u_reg (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .valid_i(v0_in), .ready_o(r0_out), .data_i(d0_in), .ctrl_i(c0_in),
    .valid_o(v0_out), .ready_i(r0_in), .data_o(d0_out), .ctrl_o(c0_out),
    .count_o(cnt0), .stall_cnt_o(stall0)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [47:0] exp1[$];
  logic [47:0] exp0[$];
  logic [47:0] e1, e0;

  logic [31:0] sd[3];
  logic [15:0] sc[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    v1_in = 1'b0; d1_in = '0; c1_in = '0; r1_in = 1'b1;
    v0_in = 1'b0; d0_in = '0; c0_in = '0; r0_in = 1'b1;
    sd[0] = 32'h11; sd[1] = 32'h22; sd[2] = 32'h33;
    sc[0] = 16'hC011; sc[1] = 16'hC022; sc[2] = 16'hC033;
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 32'(v1_out), 32'h0);
    check("rst_data", d1_out, 32'h0);
    check("rst_ctrl", 32'(c1_out), 32'h0);
    check("rst_count", 32'(cnt1), 32'h0);
    check("rst_stall", 32'(stall1), 32'h0);
    check("rst_ready", 32'(r1_out), 32'h1);

    // Monitor: pops on each delivered beat, pushes on each accepted beat
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (v1_out && r1_in) begin
            if (exp1.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL skid_unexpected_beat: got %0h, expected no beat", d1_out);
            end else begin
              e1 = exp1.pop_front();
              check("skid_data", d1_out, e1[31:0]);
              check("skid_ctrl", 32'(c1_out), 32'(e1[47:32]));
            end
          end
          if (!v1_out) check("skid_bubble_ctrl", 32'(c1_out), 32'h0);
          if (v1_in && r1_out && !flush) exp1.push_back({c1_in, d1_in});
          if (v0_out && r0_in) begin
            if (exp0.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL reg_unexpected_beat: got %0h, expected no beat", d0_out);
            end else begin
              e0 = exp0.pop_front();
              check("reg_data", d0_out, e0[31:0]);
              check("reg_ctrl", 32'(c0_out), 32'(e0[47:32]));
            end
          end
          if (v0_in && r0_out && !flush) exp0.push_back({c0_in, d0_in});
        end
      end
    join_none

    step();
    rst = 1'b0;

    // Streaming with ready_i=1
    r1_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v1_in = 1'b1; d1_in = sd[i]; c1_in = sc[i];
      at_neg();
      check("stream_ready", 32'(r1_out), 32'h1);
      if (i > 0) check("stream_count", 32'(cnt1), 32'h1);
      step();
    end
    v1_in = 1'b0;
    at_neg();
    check("stream_tail_count", 32'(cnt1), 32'h1);
    check("stream_stall", 32'(stall1), 32'h0);
    step();
    at_neg();
    check("stream_drained", 32'(v1_out), 32'h0);
    check("stream_drained_count", 32'(cnt1), 32'h0);

    // Backpressure fills both entries, then drains in order
    step();
    r1_in = 1'b0;
    v1_in = 1'b1; d1_in = 32'hA1; c1_in = 16'h00A1;
    at_neg();
    check("bp_a_ready", 32'(r1_out), 32'h1);
    step();
    d1_in = 32'hB1; c1_in = 16'h00B1;
    at_neg();
    check("bp_head_a", d1_out, 32'hA1);
    check("bp_b_ready", 32'(r1_out), 32'h1);
    step();
    d1_in = 32'hC1; c1_in = 16'h00C1;
    at_neg();
    check("bp_count_two", 32'(cnt1), 32'h2);
    check("bp_ready_low", 32'(r1_out), 32'h0);
    check("bp_hold_a", d1_out, 32'hA1);
    check("bp_stall_1", 32'(stall1), 32'h1);
    step();
    at_neg();
    check("bp_hold_a2", d1_out, 32'hA1);
    check("bp_hold_ctrl", 32'(c1_out), 32'h00A1);
    check("bp_stall_2", 32'(stall1), 32'h2);
    step();
    r1_in = 1'b1;
    at_neg();
    check("bp_ready_still_low", 32'(r1_out), 32'h0);
    step();
    at_neg();
    check("bp_ready_back", 32'(r1_out), 32'h1);
    step();
    v1_in = 1'b0;
    at_neg();
    step();
    at_neg();
    check("bp_empty", 32'(v1_out), 32'h0);
    check("bp_stall_final", 32'(stall1), 32'h3);

    // Flush with two entries and an incoming beat
    step();
    r1_in = 1'b0;
    v1_in = 1'b1; d1_in = 32'hA2; c1_in = 16'h00A2;
    at_neg();
    step();
    d1_in = 32'hB2; c1_in = 16'h00B2;
    at_neg();
    step();
    flush = 1'b1; d1_in = 32'hEE; c1_in = 16'hFFFF;
    at_neg();
    check("fl_pre_count", 32'(cnt1), 32'h2);
    step();
    flush = 1'b0; v1_in = 1'b0;
    check("fl_valid", 32'(v1_out), 32'h0);
    check("fl_ctrl", 32'(c1_out), 32'h0);
    check("fl_count", 32'(cnt1), 32'h0);
    check("fl_ready", 32'(r1_out), 32'h1);
    check("fl_stall_kept", 32'(stall1), 32'h5);
    exp1.delete();
    r1_in = 1'b1;
    step();
    step();
    check("fl_no_ghost", 32'(v1_out), 32'h0);

    // Flush in ONE with ready_o=1: head delivered, incoming beat dropped
    v1_in = 1'b1; d1_in = 32'h44; c1_in = 16'h0044;
    at_neg();
    step();
    flush = 1'b1; d1_in = 32'h55; c1_in = 16'hFFFF;
    at_neg();
    check("fl1_ready", 32'(r1_out), 32'h1);
    step();
    flush = 1'b0; v1_in = 1'b0;
    check("fl1_valid", 32'(v1_out), 32'h0);
    check("fl1_count", 32'(cnt1), 32'h0);
    exp1.delete();
    step();
    check("fl1_no_ghost", 32'(v1_out), 32'h0);

    // Asynchronous reset mid-cycle while holding two entries
    r1_in = 1'b0;
    v1_in = 1'b1; d1_in = 32'hE1; c1_in = 16'h00E1;
    at_neg();
    step();
    d1_in = 32'hF1; c1_in = 16'h00F1;
    at_neg();
    step();
    v1_in = 1'b0;
    check("ar_pre_count", 32'(cnt1), 32'h2);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(v1_out), 32'h0);
    check("ar_data", d1_out, 32'h0);
    check("ar_ctrl", 32'(c1_out), 32'h0);
    check("ar_count", 32'(cnt1), 32'h0);
    check("ar_stall", 32'(stall1), 32'h0);
    check("ar_ready", 32'(r1_out), 32'h1);
    exp1.delete();
    step();
    rst = 1'b0;
    r1_in = 1'b1;
    v1_in = 1'b1; d1_in = 32'h77; c1_in = 16'h0077;
    at_neg();
    step();
    v1_in = 1'b0;
    check("ar_lat_valid", 32'(v1_out), 32'h1);
    check("ar_lat_data", d1_out, 32'h77);
    step();

    // Stall counter saturation at 4 bits
    r1_in = 1'b0;
    v1_in = 1'b1; d1_in = 32'h66; c1_in = 16'h0066;
    at_neg();
    step();
    v1_in = 1'b0;
    repeat (10) step();
    check("sat_stall_10", 32'(stall1), 32'hA);
    repeat (10) step();
    check("sat_stall_max", 32'(stall1), 32'hF);
    check("sat_hold_data", d1_out, 32'h66);
    r1_in = 1'b1;
    at_neg();
    step();
    check("sat_drained", 32'(v1_out), 32'h0);
    check("sat_stall_kept", 32'(stall1), 32'hF);

    // Single-register build: combinational ready_o, occupancy at most 1
    step();
    v0_in = 1'b1; d0_in = 32'h91; c0_in = 16'h0091; r0_in = 1'b1;
    at_neg();
    check("s0_ready_empty", 32'(r0_out), 32'h1);
    check("s0_count_empty", 32'(cnt0), 32'h0);
    step();
    d0_in = 32'h92; c0_in = 16'h0092; r0_in = 1'b0;
    #1;
    check("s0_ready_stall", 32'(r0_out), 32'h0);
    check("s0_count_one", 32'(cnt0), 32'h1);
    at_neg();
    step();
    check("s0_count_held", 32'(cnt0), 32'h1);
    r0_in = 1'b1;
    #1;
    check("s0_ready_follow", 32'(r0_out), 32'h1);
    at_neg();
    step();
    v0_in = 1'b0;
    at_neg();
    check("s0_count_stream", 32'(cnt0), 32'h1);
    check("s0_head_92", d0_out, 32'h92);
    step();
    check("s0_empty", 32'(v0_out), 32'h0);
    check("s0_count_zero", 32'(cnt0), 32'h0);
    check("s0_stall", 32'(stall0), 32'h1);

    step();
    check("skid_all_delivered", 32'(exp1.size()), 32'h0);
    check("reg_all_delivered", 32'(exp0.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
